instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have the following ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- in_op  in  6  operation code, of type op_e.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  32  byte-offset or value immediate, two's complement.
- addr_clr  in  1  pulse; restarts the address counter at 0.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  encoded RV32I instruction word.
- out_addr  out  32  byte address assigned to out_instr.
- out_err  out  1  request was illegal; out_instr is the NOP.
- instr_count  out  16  number of words accepted since reset.

Function
REQ-002 op_e SHALL enumerate exactly these 37 ops, in this order:
- ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
- ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI
- LB LH LW LBU LHU SB SH SW
- BEQ BNE BLT BGE BLTU BGEU
- JAL JALR LUI AUIPC
Values 37..63 SHALL be illegal.
REQ-003 Encoding SHALL follow the RV32I base formats R/I/S/B/U/J, with standard opcode, funct3 and funct7[5] per op.
REQ-004 Fields not used by the format SHALL be encoded as 0 (e.g. rs2 for I-type, rd for S/B).
REQ-005 Immediate legality SHALL be checked per format:
- I/S/JALR/loads: signed 12-bit.
- B: signed 13-bit with imm[0]=0.
- J: signed 21-bit with imm[0]=0.
- U: in_imm[11:0]=0, placed from in_imm[31:12].
- SLLI/SRLI/SRAI: 0..31.
REQ-006 An illegal op or illegal immediate SHALL produce out_instr=0x00000013 (ADDI x0,x0,0) and out_err=1. The word is still emitted, still addressed and still counted.
REQ-007 Handshake: a request is accepted when in_valid && in_ready. A word is consumed when out_valid && out_ready.
REQ-008 in_ready SHALL equal !out_valid || out_ready (one-entry registered stage, full throughput).
REQ-009 Latency SHALL be 1 cycle: a request accepted in cycle N is presented on the outputs in cycle N+1.
REQ-010 While out_valid && !out_ready, out_instr, out_addr and out_err SHALL hold stable.
REQ-011 out_valid SHALL drop the cycle after consumption if no new request was accepted.
REQ-012 Address counter behaviour:
- Each accepted request SHALL take the current counter value as its out_addr.
- The counter then increments by 4, wrapping modulo 2^32 (0xFFFFFFFC -> 0).
REQ-013 When addr_clr is asserted:
- With no accept in the same cycle, the counter SHALL become 0.
- With a simultaneous accept, that request SHALL get address 0 and the counter SHALL become 4.
REQ-014 instr_count SHALL increment on each accept and saturate at 0xFFFF. addr_clr SHALL NOT affect it.
REQ-015 The input fields SHALL be sampled only on accept. The outputs SHALL NOT depend combinationally on in_* except in_ready.

Reset
REQ-016 Reset SHALL have priority over all other inputs, including an accept or addr_clr in the same cycle.
REQ-017 During and after reset:
- out_valid=0, out_instr=0, out_addr=0, out_err=0.
- Address counter=0, instr_count=0.
- in_ready=1 in the first cycle after reset deasserts.
REQ-018 Reset asserted while a word is stalled SHALL discard that word; it SHALL never be presented.

Structure
REQ-019 op_e, the format-type enum, the opcode constants and the NOP constant 0x00000013 SHALL live in the shared package riscv_pkg.
REQ-020 Combinational encoding and legality checking SHALL be one sub-module, instr_pack (op+fields -> word, err). instr_encoder SHALL hold the handshake register, address counter and count.

Verification
REQ-021 ADD rd=3,rs1=1,rs2=2 -> out_instr=0x002081B3, out_addr=0, out_err=0, one cycle later.
REQ-022 Back-to-back, out_ready=1:
- ADDI rd=1,rs1=0,imm=-1 -> 0xFFF00093 at addr 0.
- SUB rd=5,rs1=6,rs2=7 -> 0x407302B3 at addr 4.
- LUI rd=2,imm=0x12345000 -> 0x12345137 at addr 8.
- No bubbles.
REQ-023 Immediate legality:
- JAL rd=1,imm=8 -> 0x008000EF.
- BEQ imm=3 -> 0x00000013, out_err=1.
- SLLI imm=32 -> 0x00000013, out_err=1.
- Address still advances by 4 for each.
REQ-024 Backpressure: with out_valid=1, hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0, no request lost. Release -> next word follows in the next cycle.
REQ-025 Counter and op boundaries:
- Preload the counter to 0xFFFFFFFC via 1073741823 accepts (or force) -> next out_addr=0xFFFFFFFC, following out_addr=0.
- addr_clr with a simultaneous accept -> out_addr=0, next out_addr=4.
- in_op=40 -> out_err=1.
REQ-026 Reset mid-stall -> out_valid=0 next cycle, out_addr/count=0, and the stalled word never appears.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I op list, format kinds, opcodes and per-op encoding fields.
package riscv_pkg;
  typedef enum logic [5:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
  } op_e;
  localparam logic [5:0] OP_COUNT = 6'd37;
  // FMT_SH is I-type with a 5-bit shamt and funct7 in the upper immediate bits
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct packed {
    fmt_e       fmt;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7b5;
  } op_info_t;
  function automatic op_info_t op_info(input op_e op);
    op_info = '{FMT_R, OPC_OP, 3'd0, 1'b0};
    case (op)
      OP_ADD:   op_info = '{FMT_R, OPC_OP, 3'd0, 1'b0};
      OP_SUB:   op_info = '{FMT_R, OPC_OP, 3'd0, 1'b1};
      OP_SLL:   op_info = '{FMT_R, OPC_OP, 3'd1, 1'b0};
      OP_SLT:   op_info = '{FMT_R, OPC_OP, 3'd2, 1'b0};
      OP_SLTU:  op_info = '{FMT_R, OPC_OP, 3'd3, 1'b0};
      OP_XOR:   op_info = '{FMT_R, OPC_OP, 3'd4, 1'b0};
      OP_SRL:   op_info = '{FMT_R, OPC_OP, 3'd5, 1'b0};
      OP_SRA:   op_info = '{FMT_R, OPC_OP, 3'd5, 1'b1};
      OP_OR:    op_info = '{FMT_R, OPC_OP, 3'd6, 1'b0};
      OP_AND:   op_info = '{FMT_R, OPC_OP, 3'd7, 1'b0};
      OP_ADDI:  op_info = '{FMT_I, OPC_OP_IMM, 3'd0, 1'b0};
      OP_SLTI:  op_info = '{FMT_I, OPC_OP_IMM, 3'd2, 1'b0};
      OP_SLTIU: op_info = '{FMT_I, OPC_OP_IMM, 3'd3, 1'b0};
      OP_XORI:  op_info = '{FMT_I, OPC_OP_IMM, 3'd4, 1'b0};
      OP_ORI:   op_info = '{FMT_I, OPC_OP_IMM, 3'd6, 1'b0};
      OP_ANDI:  op_info = '{FMT_I, OPC_OP_IMM, 3'd7, 1'b0};
      OP_SLLI:  op_info = '{FMT_SH, OPC_OP_IMM, 3'd1, 1'b0};
      OP_SRLI:  op_info = '{FMT_SH, OPC_OP_IMM, 3'd5, 1'b0};
      OP_SRAI:  op_info = '{FMT_SH, OPC_OP_IMM, 3'd5, 1'b1};
      OP_LB:    op_info = '{FMT_I, OPC_LOAD, 3'd0, 1'b0};
      OP_LH:    op_info = '{FMT_I, OPC_LOAD, 3'd1, 1'b0};
      OP_LW:    op_info = '{FMT_I, OPC_LOAD, 3'd2, 1'b0};
      OP_LBU:   op_info = '{FMT_I, OPC_LOAD, 3'd4, 1'b0};
      OP_LHU:   op_info = '{FMT_I, OPC_LOAD, 3'd5, 1'b0};
      OP_SB:    op_info = '{FMT_S, OPC_STORE, 3'd0, 1'b0};
      OP_SH:    op_info = '{FMT_S, OPC_STORE, 3'd1, 1'b0};
      OP_SW:    op_info = '{FMT_S, OPC_STORE, 3'd2, 1'b0};
      OP_BEQ:   op_info = '{FMT_B, OPC_BRANCH, 3'd0, 1'b0};
      OP_BNE:   op_info = '{FMT_B, OPC_BRANCH, 3'd1, 1'b0};
      OP_BLT:   op_info = '{FMT_B, OPC_BRANCH, 3'd4, 1'b0};
      OP_BGE:   op_info = '{FMT_B, OPC_BRANCH, 3'd5, 1'b0};
      OP_BLTU:  op_info = '{FMT_B, OPC_BRANCH, 3'd6, 1'b0};
      OP_BGEU:  op_info = '{FMT_B, OPC_BRANCH, 3'd7, 1'b0};
      OP_JAL:   op_info = '{FMT_J, OPC_JAL, 3'd0, 1'b0};
      OP_JALR:  op_info = '{FMT_I, OPC_JALR, 3'd0, 1'b0};
      OP_LUI:   op_info = '{FMT_U, OPC_LUI, 3'd0, 1'b0};
      OP_AUIPC: op_info = '{FMT_U, OPC_AUIPC, 3'd0, 1'b0};
      default:  op_info = '{FMT_R, OPC_OP, 3'd0, 1'b0};
    endcase
  endfunction
endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational RV32I encoder with per-format immediate legality.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);
  op_info_t    info;
  logic [31:0] word;
  logic        imm_ok;
  logic        s12;
  logic        s13;
  logic        s21;
  always_comb begin
    info = op_info(op_e'(op));
    s12 = &imm[31:11] | ~|imm[31:11];
    s13 = (&imm[31:12] | ~|imm[31:12]) & ~imm[0];
    s21 = (&imm[31:20] | ~|imm[31:20]) & ~imm[0];
    word = '0;
    imm_ok = 1'b1;
    case (info.fmt)
      FMT_R: word = {1'b0, info.f7b5, 5'd0, rs2, rs1, info.f3, rd, info.opc};
      FMT_I: begin
        word = {imm[11:0], rs1, info.f3, rd, info.opc};
        imm_ok = s12;
      end
      FMT_SH: begin
        word = {1'b0, info.f7b5, 5'd0, imm[4:0], rs1, info.f3, rd, info.opc};
        imm_ok = ~|imm[31:5];
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, info.f3, imm[4:0], info.opc};
        imm_ok = s12;
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, info.f3, imm[4:1], imm[11], info.opc};
        imm_ok = s13;
      end
      FMT_U: begin
        word = {imm[31:12], rd, info.opc};
        imm_ok = ~|imm[11:0];
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, info.opc};
        imm_ok = s21;
      end
      default: word = '0;
    endcase
    err = (op >= OP_COUNT) || !imm_ok;
    instr = err ? NOP : word;
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: one-entry registered encode stage with byte-address counter and accept count.
module instr_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        addr_clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [15:0] instr_count
);
  logic        accept;
  logic [31:0] pack_instr;
  logic        pack_err;
  logic        out_valid_d, out_valid_q;
  logic [31:0] out_instr_d, out_instr_q;
  logic [31:0] out_addr_d, out_addr_q;
  logic        out_err_d, out_err_q;
  logic [31:0] addr_d, addr_q;
  logic [15:0] count_d, count_q;
  instr_pack u_pack (
    .op    (in_op),
    .rd    (in_rd),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .imm   (in_imm),
    .instr (pack_instr),
    .err   (pack_err)
  );
  assign in_ready = !out_valid_q || out_ready;
  assign accept = in_valid && in_ready;
  // addr_clr with an accept hands address 0 to that request, so the counter lands on 4
  always_comb begin
    out_valid_d = accept || (out_valid_q && !out_ready);
    out_instr_d = accept ? pack_instr : out_instr_q;
    out_err_d = accept ? pack_err : out_err_q;
    out_addr_d = accept ? (addr_clr ? 32'd0 : addr_q) : out_addr_q;
    addr_d = accept ? out_addr_d + 32'd4 : (addr_clr ? 32'd0 : addr_q);
    count_d = (accept && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q <= '0;
      out_err_q <= 1'b0;
      addr_q <= '0;
      count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q <= out_addr_d;
      out_err_q <= out_err_d;
      addr_q <= addr_d;
      count_q <= count_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr = out_addr_q;
  assign out_err = out_err_q;
  assign instr_count = count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench with an arithmetic RV32I reference encoder.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_op = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        addr_clr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [15:0] instr_count;

  instr_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .addr_clr(addr_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;
  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  bit          m_valid = 0;
  logic [31:0] m_addr = '0;
  int          m_count = 0;

  // kind: 0 R, 1 I, 2 shift-imm, 3 S, 4 B, 5 J, 6 U
  int opc_t[37] = '{'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h33,
                    'h13, 'h13, 'h13, 'h13, 'h13, 'h13, 'h13, 'h13, 'h13,
                    'h03, 'h03, 'h03, 'h03, 'h03, 'h23, 'h23, 'h23,
                    'h63, 'h63, 'h63, 'h63, 'h63, 'h63, 'h6F, 'h67, 'h37, 'h17};
  int f3_t[37]  = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7, 0, 2, 3, 4, 6, 7, 1, 5, 5,
                    0, 1, 2, 4, 5, 0, 1, 2, 0, 1, 4, 5, 6, 7, 0, 0, 0, 0};
  int kind_t[37] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 2, 2, 2,
                     1, 1, 1, 1, 1, 3, 3, 3, 4, 4, 4, 4, 4, 4, 5, 1, 6, 6};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_enc(input int op, input int rd, input int rs1, input int rs2,
                                  input logic [31:0] imm, output logic [31:0] w, output bit e);
    longint s, u, x;
    int k, f7;
    s = longint'($signed(imm));
    u = longint'(imm);
    x = 0;
    e = 0;
    if (op > 36) begin
      e = 1;
    end else begin
      k = kind_t[op];
      f7 = (op == 1 || op == 7 || op == 18) ? 1 : 0;
      case (k)
        0: x = f7 << 30;
        1: begin e = (s < -2048 || s > 2047); x = (s & 'hFFF) << 20; end
        2: begin e = (u > 31); x = (f7 << 30) + (u << 20); end
        3: begin e = (s < -2048 || s > 2047); x = (((s >> 5) & 'h7F) << 25) + ((s & 'h1F) << 7); end
        4: begin
          e = (s < -4096 || s > 4094 || s % 2 != 0);
          x = (((s >> 12) & 1) << 31) + (((s >> 5) & 'h3F) << 25) + (((s >> 1) & 'hF) << 8) + (((s >> 11) & 1) << 7);
        end
        5: begin
          e = (s < -1048576 || s > 1048574 || s % 2 != 0);
          x = (((s >> 20) & 1) << 31) + (((s >> 1) & 'h3FF) << 21) + (((s >> 11) & 1) << 20) + (((s >> 12) & 'hFF) << 12);
        end
        default: begin e = (u % 4096 != 0); x = u; end
      endcase
      x = x + opc_t[op] + (f3_t[op] << 12);
      if (k inside {0, 1, 2, 5, 6}) x = x + (rd << 7);
      if (k inside {0, 1, 2, 3, 4}) x = x + (rs1 << 15);
      if (k inside {0, 3, 4}) x = x + (rs2 << 20);
    end
    w = e ? 32'h0000_0013 : x[31:0];
  endfunction

  // one clock: drive inputs, advance the model at the negedge, return at posedge+1
  task automatic step(input bit v, input int op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input bit rdy, input bit clr,
                      input bit rst, input bit use_k, input logic [31:0] kw, input bit ke);
    logic [31:0] w, a;
    bit e, acc;
    reset = rst; in_valid = v; in_op = 6'(op); in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; out_ready = rdy; addr_clr = clr;
    @(negedge clk);
    #1;
    if (rst) begin
      sb.delete();
      m_valid = 0;
      m_addr = '0;
      m_count = 0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!m_valid || rdy));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("instr_count", 32'(instr_count), 32'(m_count));
      acc = v && (!m_valid || rdy);
      if (acc) begin
        ref_enc(op, int'(rd), int'(rs1), int'(rs2), imm, w, e);
        if (use_k) begin w = kw; e = ke; end
        a = clr ? 32'd0 : m_addr;
        sb.push_back('{w, a, e});
        m_addr = a + 32'd4;
        if (m_count < 65535) m_count++;
      end else if (clr) begin
        m_addr = '0;
      end
      m_valid = acc || (m_valid && !rdy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [31:0] imm, input logic [31:0] kw, input bit ke);
    step(1, op, rd, rs1, rs2, imm, 1, 0, 0, 1, kw, ke);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic rstep(input int rst_per, input bit v, input bit rdy);
    int op, m;
    logic [31:0] imm;
    op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(37, 63)) : int'($urandom_range(0, 36));
    m = $urandom_range(0, 3);
    imm = m == 0 ? $urandom : m == 1 ? 32'($urandom_range(0, 10000)) - 32'd5000
        : m == 2 ? ($urandom & 32'hFFFFF000) : 32'($urandom_range(0, 40));
    step(v, op, 5'($urandom), 5'($urandom), 5'($urandom), imm, rdy, $urandom_range(0, 15) == 0,
         rst_per > 0 && $urandom_range(1, rst_per) == 1, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 0, 0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_instr", out_instr, 32'd0);
    chk("rst out_addr", out_addr, 32'd0);
    chk("rst out_err", 32'(out_err), 32'd0);
    chk("rst instr_count", 32'(instr_count), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected word: got %h at %h, expected none", out_instr, out_addr);
      end else begin
        chk("out_instr", out_instr, sb[0].instr);
        chk("out_addr", out_addr, sb[0].addr);
        chk("out_err", 32'(out_err), 32'(sb[0].err));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset(2);
    put(0, 3, 1, 2, 0, 32'h002081B3, 0);
    idle();
    do_reset(1);
    put(10, 1, 0, 0, 32'hFFFFFFFF, 32'hFFF00093, 0);
    put(1, 5, 6, 7, 0, 32'h407302B3, 0);
    put(35, 2, 0, 0, 32'h12345000, 32'h12345137, 0);
    put(33, 1, 0, 0, 32'd8, 32'h008000EF, 0);
    put(27, 0, 1, 2, 32'd3, 32'h00000013, 1);
    put(16, 1, 1, 0, 32'd32, 32'h00000013, 1);
    put(40, 1, 1, 1, 32'd0, 32'h00000013, 1);
    // stall three cycles with a pending request, then release
    put(0, 4, 4, 4, 0, 32'h00420233, 0);
    for (int i = 0; i < 3; i++) rstep(0, 1, 0);
    for (int i = 0; i < 3; i++) rstep(0, 1, 1);
    idle();
    force dut.addr_q = 32'hFFFFFFFC;
    #1;
    release dut.addr_q;
    m_addr = 32'hFFFFFFFC;
    rstep(0, 1, 1);
    rstep(0, 1, 1);
    step(1, 0, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0);
    rstep(0, 1, 1);
    idle();
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    m_count = 65534;
    for (int i = 0; i < 4; i++) rstep(0, 1, 1);
    idle();
    for (int i = 0; i < 2000; i++) rstep(300, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    // reset lands on a stalled word: it must never be presented
    idle();
    put(0, 9, 9, 9, 0, 32'h009484B3, 0);
    step(1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 0, 0);
    chk("stall rst out_valid", 32'(out_valid), 32'd0);
    chk("stall rst out_addr", out_addr, 32'd0);
    chk("stall rst count", 32'(instr_count), 32'd0);
    for (int i = 0; i < 4; i++) idle();
    chk("drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
